// File: rtl/alu_operand_collector.sv
// Single-entry ALU operand collector: captures rs1/rs2 values or RRF tags at dispatch,
// snoops two CDBs for missing operands and presents resolved sources over valid/ready.
`ifndef ADDR_LEN
`define ADDR_LEN 32
`endif
`ifndef DATA_LEN
`define DATA_LEN 32
`endif
`ifndef SRC_A_SEL_WIDTH
`define SRC_A_SEL_WIDTH 2
`define SRC_A_RS1 2'd0
`define SRC_A_PC 2'd1
`define SRC_A_ZERO 2'd2
`endif
`ifndef SRC_B_SEL_WIDTH
`define SRC_B_SEL_WIDTH 2
`define SRC_B_RS2 2'd0
`define SRC_B_IMM 2'd1
`define SRC_B_FOUR 2'd2
`define SRC_B_ZERO 2'd3
`endif

module alu_operand_collector #(
   parameter int TAG_W = 6
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        disp_valid,
   output logic                        disp_ready,
   input  logic [`ADDR_LEN-1:0]        disp_pc,
   input  logic [`DATA_LEN-1:0]        disp_imm,
   input  logic [`SRC_A_SEL_WIDTH-1:0] disp_src_a_sel,
   input  logic [`SRC_B_SEL_WIDTH-1:0] disp_src_b_sel,
   input  logic [`DATA_LEN-1:0]        disp_rs1,
   input  logic [`DATA_LEN-1:0]        disp_rs2,
   input  logic                        disp_rs1_rdy,
   input  logic                        disp_rs2_rdy,
   input  logic [TAG_W-1:0]            disp_dst_tag,
   input  logic                        cdb0_valid,
   input  logic [TAG_W-1:0]            cdb0_tag,
   input  logic [`DATA_LEN-1:0]        cdb0_data,
   input  logic                        cdb1_valid,
   input  logic [TAG_W-1:0]            cdb1_tag,
   input  logic [`DATA_LEN-1:0]        cdb1_data,
   input  logic                        kill,
   output logic                        iss_valid,
   input  logic                        iss_ready,
   output logic [`DATA_LEN-1:0]        iss_src_a,
   output logic [`DATA_LEN-1:0]        iss_src_b,
   output logic [TAG_W-1:0]            iss_dst_tag
);

   localparam logic [1:0] ST_EMPTY = 2'd0;
   localparam logic [1:0] ST_WAIT  = 2'd1;
   localparam logic [1:0] ST_READY = 2'd2;

   logic [1:0]           state_q, state_d;
   logic [`DATA_LEN-1:0] a_val_q, a_val_d, b_val_q, b_val_d;
   logic [TAG_W-1:0]     a_tag_q, a_tag_d, b_tag_q, b_tag_d, dst_q, dst_d;
   logic                 a_rdy_q, a_rdy_d, b_rdy_q, b_rdy_d;
   logic                 disp_accept;
   logic [TAG_W-1:0]     a_tag_cur, b_tag_cur;
   logic                 a_hit, b_hit;
   logic [`DATA_LEN-1:0] a_cdb_data, b_cdb_data;

   assign disp_ready  = (state_q == ST_EMPTY) | ((state_q == ST_READY) & iss_ready);
   assign disp_accept = disp_valid & disp_ready & ~kill;
   assign iss_valid   = (state_q == ST_READY);

   // Dispatch and WAIT never overlap, so one comparator pair per operand serves both.
   assign a_tag_cur  = disp_accept ? disp_rs1[TAG_W-1:0] : a_tag_q;
   assign b_tag_cur  = disp_accept ? disp_rs2[TAG_W-1:0] : b_tag_q;
   assign a_hit      = (cdb0_valid & (cdb0_tag == a_tag_cur)) |
                       (cdb1_valid & (cdb1_tag == a_tag_cur));
   assign b_hit      = (cdb0_valid & (cdb0_tag == b_tag_cur)) |
                       (cdb1_valid & (cdb1_tag == b_tag_cur));
   assign a_cdb_data = (cdb0_valid & (cdb0_tag == a_tag_cur)) ? cdb0_data : cdb1_data;
   assign b_cdb_data = (cdb0_valid & (cdb0_tag == b_tag_cur)) ? cdb0_data : cdb1_data;

   always_comb begin
      state_d = state_q;
      a_val_d = a_val_q;
      b_val_d = b_val_q;
      a_tag_d = a_tag_q;
      b_tag_d = b_tag_q;
      a_rdy_d = a_rdy_q;
      b_rdy_d = b_rdy_q;
      dst_d   = dst_q;
      if (kill) begin
         state_d = ST_EMPTY;
         a_rdy_d = 1'b0;
         b_rdy_d = 1'b0;
      end else if (disp_accept) begin
         dst_d   = disp_dst_tag;
         a_tag_d = disp_rs1[TAG_W-1:0];
         b_tag_d = disp_rs2[TAG_W-1:0];
         if (disp_src_a_sel == `SRC_A_RS1) begin
            a_rdy_d = disp_rs1_rdy | a_hit;
            a_val_d = disp_rs1_rdy ? disp_rs1 : (a_hit ? a_cdb_data : '0);
         end else begin
            a_rdy_d = 1'b1;
            a_val_d = (disp_src_a_sel == `SRC_A_PC) ? `DATA_LEN'(disp_pc) : '0;
         end
         if (disp_src_b_sel == `SRC_B_RS2) begin
            b_rdy_d = disp_rs2_rdy | b_hit;
            b_val_d = disp_rs2_rdy ? disp_rs2 : (b_hit ? b_cdb_data : '0);
         end else begin
            b_rdy_d = 1'b1;
            if (disp_src_b_sel == `SRC_B_IMM)       b_val_d = disp_imm;
            else if (disp_src_b_sel == `SRC_B_FOUR) b_val_d = `DATA_LEN'(4);
            else                                    b_val_d = '0;
         end
         state_d = (a_rdy_d & b_rdy_d) ? ST_READY : ST_WAIT;
      end else if (state_q == ST_WAIT) begin
         if (!a_rdy_q && a_hit) begin
            a_rdy_d = 1'b1;
            a_val_d = a_cdb_data;
         end
         if (!b_rdy_q && b_hit) begin
            b_rdy_d = 1'b1;
            b_val_d = b_cdb_data;
         end
         state_d = (a_rdy_d & b_rdy_d) ? ST_READY : ST_WAIT;
      end else if ((state_q == ST_READY) && iss_ready) begin
         state_d = ST_EMPTY;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= ST_EMPTY;
         a_val_q     <= '0;
         b_val_q     <= '0;
         a_tag_q     <= '0;
         b_tag_q     <= '0;
         a_rdy_q     <= 1'b0;
         b_rdy_q     <= 1'b0;
         dst_q       <= '0;
         iss_src_a   <= '0;
         iss_src_b   <= '0;
         iss_dst_tag <= '0;
      end else begin
         state_q <= state_d;
         a_val_q <= a_val_d;
         b_val_q <= b_val_d;
         a_tag_q <= a_tag_d;
         b_tag_q <= b_tag_d;
         a_rdy_q <= a_rdy_d;
         b_rdy_q <= b_rdy_d;
         dst_q   <= dst_d;
         // Output registers only move when an entry becomes (or stays) issuable.
         if (state_d == ST_READY) begin
            iss_src_a   <= a_val_d;
            iss_src_b   <= b_val_d;
            iss_dst_tag <= dst_d;
         end
      end
   end

endmodule

// File: tb/tb_alu_operand_collector.sv
// Directed-vector bench for alu_operand_collector with hand-computed expectations.
`ifndef ADDR_LEN
`define ADDR_LEN 32
`endif
`ifndef DATA_LEN
`define DATA_LEN 32
`endif

module tb_alu_operand_collector;

   localparam int TAG_W = 6;

   logic              clk = 1'b0;
   logic              reset;
   logic              disp_valid, disp_ready;
   logic [31:0]       disp_pc, disp_imm, disp_rs1, disp_rs2;
   logic [1:0]        disp_src_a_sel, disp_src_b_sel;
   logic              disp_rs1_rdy, disp_rs2_rdy;
   logic [TAG_W-1:0]  disp_dst_tag;
   logic              cdb0_valid, cdb1_valid;
   logic [TAG_W-1:0]  cdb0_tag, cdb1_tag;
   logic [31:0]       cdb0_data, cdb1_data;
   logic              kill, iss_valid, iss_ready;
   logic [31:0]       iss_src_a, iss_src_b;
   logic [TAG_W-1:0]  iss_dst_tag;

   int errors = 0;
   int checks = 0;

   alu_operand_collector #(.TAG_W(TAG_W)) dut (
      .clk(clk), .reset(reset),
      .disp_valid(disp_valid), .disp_ready(disp_ready),
      .disp_pc(disp_pc), .disp_imm(disp_imm),
      .disp_src_a_sel(disp_src_a_sel), .disp_src_b_sel(disp_src_b_sel),
      .disp_rs1(disp_rs1), .disp_rs2(disp_rs2),
      .disp_rs1_rdy(disp_rs1_rdy), .disp_rs2_rdy(disp_rs2_rdy),
      .disp_dst_tag(disp_dst_tag),
      .cdb0_valid(cdb0_valid), .cdb0_tag(cdb0_tag), .cdb0_data(cdb0_data),
      .cdb1_valid(cdb1_valid), .cdb1_tag(cdb1_tag), .cdb1_data(cdb1_data),
      .kill(kill),
      .iss_valid(iss_valid), .iss_ready(iss_ready),
      .iss_src_a(iss_src_a), .iss_src_b(iss_src_b), .iss_dst_tag(iss_dst_tag)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic dispatch(input logic [1:0] sa, input logic [1:0] sb, input logic [31:0] pc,
                           input logic [31:0] imm, input logic [31:0] rs1, input logic r1,
                           input logic [31:0] rs2, input logic r2, input logic [5:0] dst);
      disp_valid = 1'b1;
      disp_src_a_sel = sa; disp_src_b_sel = sb;
      disp_pc = pc; disp_imm = imm;
      disp_rs1 = rs1; disp_rs1_rdy = r1;
      disp_rs2 = rs2; disp_rs2_rdy = r2;
      disp_dst_tag = dst;
   endtask

   task automatic clear_cdb();
      cdb0_valid = 1'b0; cdb0_tag = '0; cdb0_data = '0;
      cdb1_valid = 1'b0; cdb1_tag = '0; cdb1_data = '0;
   endtask

   initial begin
      reset = 1'b1; kill = 1'b0; iss_ready = 1'b1;
      disp_valid = 1'b0;
      dispatch(2'd0, 2'd0, '0, '0, '0, 1'b0, '0, 1'b0, '0);
      disp_valid = 1'b0;
      clear_cdb();
      step(); step();
      check("rst_valid", {31'd0, iss_valid}, 32'd0);
      check("rst_src_a", iss_src_a, 32'd0);
      check("rst_src_b", iss_src_b, 32'd0);
      check("rst_dst", {26'd0, iss_dst_tag}, 32'd0);
      check("rst_disp_ready", {31'd0, disp_ready}, 32'd1);
      reset = 1'b0;

      // Ready dispatch: PC + 4
      dispatch(2'd1, 2'd2, 32'h100, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0, 6'd1);
      step(); disp_valid = 1'b0;
      check("rdy_valid", {31'd0, iss_valid}, 32'd1);
      check("rdy_src_a", iss_src_a, 32'h100);
      check("rdy_src_b", iss_src_b, 32'd4);
      check("rdy_dst", {26'd0, iss_dst_tag}, 32'd1);
      step();
      check("rdy_empty", {31'd0, iss_valid}, 32'd0);
      check("rdy_hold_a", iss_src_a, 32'h100);

      // Wakeup of rs1 tag 5 from cdb1 three cycles later
      dispatch(2'd0, 2'd0, 32'h0, 32'h0, 32'd5, 1'b0, 32'h7, 1'b1, 6'd2);
      step(); disp_valid = 1'b0;
      check("wk_wait0", {31'd0, iss_valid}, 32'd0);
      check("wk_disp_ready", {31'd0, disp_ready}, 32'd0);
      step(); check("wk_wait1", {31'd0, iss_valid}, 32'd0);
      step(); check("wk_wait2", {31'd0, iss_valid}, 32'd0);
      cdb0_valid = 1'b1; cdb0_tag = 6'd6; cdb0_data = 32'hBAD;
      cdb1_valid = 1'b1; cdb1_tag = 6'd5; cdb1_data = 32'hDEAD;
      step(); clear_cdb();
      check("wk_valid", {31'd0, iss_valid}, 32'd1);
      check("wk_src_a", iss_src_a, 32'hDEAD);
      check("wk_src_b", iss_src_b, 32'h7);
      check("wk_dst", {26'd0, iss_dst_tag}, 32'd2);
      step();

      // Both operands on tag 3; cdb0 takes priority
      dispatch(2'd0, 2'd0, 32'h0, 32'h0, 32'd3, 1'b0, 32'd3, 1'b0, 6'd3);
      step(); disp_valid = 1'b0;
      check("dual_wait", {31'd0, iss_valid}, 32'd0);
      cdb0_valid = 1'b1; cdb0_tag = 6'd3; cdb0_data = 32'h11;
      cdb1_valid = 1'b1; cdb1_tag = 6'd3; cdb1_data = 32'h22;
      step(); clear_cdb();
      check("dual_valid", {31'd0, iss_valid}, 32'd1);
      check("dual_src_a", iss_src_a, 32'h11);
      check("dual_src_b", iss_src_b, 32'h11);
      step();

      // Dispatch-cycle snoop for rs2 tag 9
      dispatch(2'd1, 2'd0, 32'h200, 32'h0, 32'h0, 1'b0, 32'd9, 1'b0, 6'd4);
      cdb0_valid = 1'b1; cdb0_tag = 6'd9; cdb0_data = 32'h55;
      step(); disp_valid = 1'b0; clear_cdb();
      check("snp_valid", {31'd0, iss_valid}, 32'd1);
      check("snp_src_a", iss_src_a, 32'h200);
      check("snp_src_b", iss_src_b, 32'h55);

      // Back-pressure with a pending dispatch, then back-to-back handoff
      iss_ready = 1'b0;
      dispatch(2'd1, 2'd1, 32'h300, 32'h44, 32'h0, 1'b0, 32'h0, 1'b0, 6'd5);
      #1;
      check("bp_disp_ready0", {31'd0, disp_ready}, 32'd0);
      for (int i = 0; i < 4; i++) begin
         step();
         check("bp_valid", {31'd0, iss_valid}, 32'd1);
         check("bp_src_b", iss_src_b, 32'h55);
         check("bp_dst", {26'd0, iss_dst_tag}, 32'd4);
      end
      iss_ready = 1'b1;
      #1;
      check("b2b_disp_ready", {31'd0, disp_ready}, 32'd1);
      step(); disp_valid = 1'b0;
      check("b2b_valid", {31'd0, iss_valid}, 32'd1);
      check("b2b_src_a", iss_src_a, 32'h300);
      check("b2b_src_b", iss_src_b, 32'h44);
      check("b2b_dst", {26'd0, iss_dst_tag}, 32'd5);
      step();
      check("b2b_empty", {31'd0, iss_valid}, 32'd0);

      // Kill in WAIT discards the entry; a later matching broadcast must not revive it
      dispatch(2'd0, 2'd1, 32'h0, 32'h1, 32'd7, 1'b0, 32'h0, 1'b0, 6'd6);
      step(); disp_valid = 1'b0;
      check("kw_disp_ready0", {31'd0, disp_ready}, 32'd0);
      kill = 1'b1;
      step(); kill = 1'b0;
      check("kw_disp_ready1", {31'd0, disp_ready}, 32'd1);
      cdb0_valid = 1'b1; cdb0_tag = 6'd7; cdb0_data = 32'h77;
      step(); clear_cdb();
      check("kw_no_revive", {31'd0, iss_valid}, 32'd0);

      // Kill overrides a same-cycle dispatch
      dispatch(2'd1, 2'd2, 32'h500, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0, 6'd7);
      kill = 1'b1;
      step(); kill = 1'b0; disp_valid = 1'b0;
      check("kd_valid", {31'd0, iss_valid}, 32'd0);
      step();
      check("kd_valid2", {31'd0, iss_valid}, 32'd0);

      // Asynchronous reset while READY
      iss_ready = 1'b0;
      dispatch(2'd1, 2'd2, 32'h400, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0, 6'd8);
      step(); disp_valid = 1'b0;
      check("ar_valid_pre", {31'd0, iss_valid}, 32'd1);
      check("ar_src_a_pre", iss_src_a, 32'h400);
      #1 reset = 1'b1;
      #1;
      check("ar_valid", {31'd0, iss_valid}, 32'd0);
      check("ar_src_a", iss_src_a, 32'd0);
      reset = 1'b0;
      step();
      check("ar_valid_post", {31'd0, iss_valid}, 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/alu_operand_collector.md
# alu_operand_collector

Single-entry operand collector between dispatch and an ALU reservation slot. It accepts one instruction whose rs1/rs2 operands are either values or rename-buffer (RRF) tags, and snoops two result broadcast buses to capture missing operands. When every selected operand is present, it presents the final ALU source operands to the issue side over a valid/ready handshake. It is the producer side of the operand-select path: it resolves `src_a_sel`/`src_b_sel` and delivers finished `alu_src_a`/`alu_src_b`-equivalent values.

## Interface
Parameters:
- TAG_W, 6, RRF tag width; tags occupy `disp_rs*[TAG_W-1:0]` when not ready.

Ports:
- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-high
- disp_valid  in  1  dispatch request
- disp_ready  out  1  collector can accept this cycle
- disp_pc  in  `ADDR_LEN  instruction PC
- disp_imm  in  `DATA_LEN  immediate
- disp_src_a_sel  in  `SRC_A_SEL_WIDTH  SRC_A_RS1 / SRC_A_PC / other
- disp_src_b_sel  in  `SRC_B_SEL_WIDTH  SRC_B_RS2 / SRC_B_IMM / SRC_B_FOUR / other
- disp_rs1, disp_rs2  in  `DATA_LEN  value if rdy, else tag in low TAG_W bits
- disp_rs1_rdy, disp_rs2_rdy  in  1  operand is a value
- disp_dst_tag  in  TAG_W  destination tag, passed through
- cdb0_valid, cdb1_valid  in  1  result broadcast valid
- cdb0_tag, cdb1_tag  in  TAG_W  broadcast tag
- cdb0_data, cdb1_data  in  `DATA_LEN  broadcast value
- kill  in  1  flush entry (mispredict)
- iss_valid  out  1  operands complete, entry issuable
- iss_ready  in  1  issue side accepts
- iss_src_a, iss_src_b  out  `DATA_LEN  resolved ALU operands
- iss_dst_tag  out  TAG_W  destination tag

## Operation
- States: EMPTY, WAIT, READY (2-bit register).
- Operand need: rs1 needed iff sel_a == SRC_A_RS1; rs2 needed iff sel_b == SRC_B_RS2. Unneeded operands are ready at dispatch.
- Source resolution at dispatch (stored, not recomputed): SRC_A_PC -> pc; SRC_B_IMM -> imm; SRC_B_FOUR -> 32'd4; any other sel encoding -> 0, treated ready.
- Dispatch accept = disp_valid & disp_ready & ~kill. Next state: READY if both operands ready after dispatch-cycle snoop, else WAIT.
- Dispatch-cycle snoop: a not-ready needed operand whose tag matches a valid CDB in the same cycle is captured as ready.
- WAIT: each not-ready operand compares its tag with cdb0 and cdb1 each cycle; on match, capture data and set ready. Both CDBs matching the same tag: cdb0 wins. Both operands may capture in one cycle (same or different CDB). WAIT -> READY when both ready after the edge.
- READY: iss_valid = 1. On iss_valid & iss_ready: if a dispatch is accepted the same cycle, load new entry; else -> EMPTY.
- disp_ready = (state == EMPTY) | (state == READY & iss_ready). Combinational from state and iss_ready; not from disp_valid.
- kill: next state EMPTY from any state. It overrides a same-cycle dispatch (dispatch is not accepted) and a same-cycle issue (the handshake still completes downstream; the collector does not care).
- iss_src_a/iss_src_b/iss_dst_tag are registered; they hold their last values when not valid.

## Timing
- Reset: state EMPTY, iss_valid 0, iss_src_a 0, iss_src_b 0, iss_dst_tag 0, operand ready bits 0. Reset mid-WAIT discards the entry.
- Dispatch with all operands ready (or matched on CDB in the dispatch cycle) at edge N: iss_valid = 1 in cycle N+1.
- CDB match in cycle M completes the last operand: iss_valid = 1 in cycle M+1.
- Back-to-back: issue and dispatch in the same cycle gives zero bubbles. Throughput is 1 instruction/cycle when operands are ready.
- iss_valid, once high, stays high with stable outputs until iss_ready or kill.
- No combinational path from cdb* or disp_* to iss_*.

## Test plan
- Ready dispatch: sel_a=SRC_A_PC, pc=0x100, sel_b=SRC_B_FOUR, iss_ready=1 -> next cycle iss_valid=1, src_a=0x100, src_b=4; then EMPTY.
- Wakeup: rs1 tag 5 not ready, rs2 rdy=0x7; cdb1 broadcasts tag 5 data 0xDEAD three cycles later -> iss_valid the cycle after, src_a=0xDEAD, src_b=0x7.
- Dual wakeup with conflict: rs1 tag 3, rs2 tag 3; cdb0 (3, 0x11) and cdb1 (3, 0x22) in the same cycle -> both operands 0x11.
- Dispatch-cycle snoop: rs2 tag 9 dispatched while cdb0 carries (9, 0x55) -> iss_valid next cycle, src_b=0x55.
- Back-pressure then back-to-back: hold iss_ready=0 for 4 cycles -> outputs stable, disp_ready=0; raise iss_ready with disp_valid -> new entry valid the next cycle, no bubble.
- kill: kill in WAIT -> EMPTY; kill with disp_valid -> not accepted, iss_valid stays 0; async reset in READY -> iss_valid 0 immediately.
